traffic_light_monitor: RTL and testbench

- Passive conformance checker on the receiving end of the traffic light controller's `ns_light`/`ew_light` interface.
- Samples the two light codes and the emergency request every clock. It decodes the phase, then checks encoding, conflicts, phase order and dwell times against the controller's timing parameters.
- Reports sticky error flags and a completed-cycle count. Sits beside the controller in system benches and in the FPGA debug build.

---
 rtl/traffic_light_monitor.sv | 169 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive conformance checker for a two-direction traffic light controller.
// Decodes the observed light codes into a phase every clock and flags illegal
// encodings, conflicting greens/yellows, out-of-order phases and wrong dwell
// times. Error flags are sticky until clear_errors; cycle_count tallies
// completed EW_Y->NS_G wraps.
module traffic_light_monitor #(
    parameter int unsigned GREEN_TIME     = 8,
    parameter int unsigned YELLOW_TIME    = 2,
    parameter int unsigned EMERGENCY_TIME = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ns_light,
    input  logic [1:0]       ew_light,
    input  logic             emergency,
    input  logic             clear_errors,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             err_encoding,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_any,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        PhNsG     = 3'd0,
        PhNsY     = 3'd1,
        PhEwG     = 3'd2,
        PhEwY     = 3'd3,
        PhAllRed  = 3'd4,
        PhUnknown = 3'd7
    } phase_e;

    phase_e           phase_q, phase_d;
    logic             locked_q, locked_d;
    logic             err_enc_q, err_enc_d;
    logic             err_conf_q, err_conf_d;
    logic             err_seq_q, err_seq_d;
    logic             err_tim_q, err_tim_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [7:0]       dwell_q, dwell_d;
    logic             emerg_q;

    phase_e samp_ph;
    logic   samp_enc;
    logic   samp_conf;
    logic   tr_ok;
    logic   tim_bad;
    logic   preempt;

    // Decode the current sample into a phase and classify illegal codes.
    always_comb begin
        samp_enc  = (ns_light == 2'b11) || (ew_light == 2'b11);
        samp_conf = !samp_enc && (ns_light != 2'b00) && (ew_light != 2'b00);
        case ({ns_light, ew_light})
            4'b10_00: samp_ph = PhNsG;
            4'b01_00: samp_ph = PhNsY;
            4'b00_10: samp_ph = PhEwG;
            4'b00_01: samp_ph = PhEwY;
            4'b00_00: samp_ph = PhAllRed;
            default:  samp_ph = PhUnknown;
        endcase
    end

    // Transition legality and dwell check for a move out of phase_q.
    // emerg_q is used because the controller's lights lag its emergency input.
    always_comb begin
        preempt = (samp_ph == PhAllRed) && emerg_q;
        case (phase_q)
            PhNsG:    tr_ok = (samp_ph == PhNsY);
            PhNsY:    tr_ok = (samp_ph == PhEwG);
            PhEwG:    tr_ok = (samp_ph == PhEwY);
            PhEwY:    tr_ok = (samp_ph == PhNsG);
            PhAllRed: tr_ok = (samp_ph == PhNsG) && !emerg_q;
            default:  tr_ok = 1'b0;
        endcase
        if (preempt) begin
            tr_ok = 1'b1;
        end
        case (phase_q)
            PhNsG, PhEwG: tim_bad = (32'(dwell_q) != GREEN_TIME);
            PhNsY, PhEwY: tim_bad = (32'(dwell_q) != YELLOW_TIME);
            PhAllRed:     tim_bad = (32'(dwell_q) < EMERGENCY_TIME);
            default:      tim_bad = 1'b0;
        endcase
    end

    // Next-state: resync, dwell tracking, sticky flags with set-over-clear.
    always_comb begin
        phase_d       = phase_q;
        locked_d      = locked_q;
        dwell_d       = dwell_q;
        cycle_count_d = cycle_count_q;
        err_enc_d     = clear_errors ? 1'b0 : err_enc_q;
        err_conf_d    = clear_errors ? 1'b0 : err_conf_q;
        err_seq_d     = clear_errors ? 1'b0 : err_seq_q;
        err_tim_d     = clear_errors ? 1'b0 : err_tim_q;

        if (samp_enc || samp_conf) begin
            phase_d  = PhUnknown;
            locked_d = 1'b0;
            dwell_d  = 8'd0;
            if (samp_enc) begin
                err_enc_d = 1'b1;
            end
            if (samp_conf) begin
                err_conf_d = 1'b1;
            end
        end else if (phase_q == PhUnknown) begin
            // Resync: adopt the phase without judging a partial dwell.
            phase_d = samp_ph;
            dwell_d = 8'd1;
        end else if (samp_ph == phase_q) begin
            dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        end else begin
            phase_d  = samp_ph;
            dwell_d  = 8'd1;
            locked_d = 1'b1;
            if (!tr_ok) begin
                err_seq_d = 1'b1;
            end
            // First exit after resync has an unknown dwell, so it is not judged.
            if (locked_q && !preempt && tim_bad) begin
                err_tim_d = 1'b1;
            end
            if (tr_ok && (phase_q == PhEwY) && (samp_ph == PhNsG)) begin
                cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PhUnknown;
            locked_q      <= 1'b0;
            err_enc_q     <= 1'b0;
            err_conf_q    <= 1'b0;
            err_seq_q     <= 1'b0;
            err_tim_q     <= 1'b0;
            cycle_count_q <= '0;
            dwell_q       <= 8'd0;
            emerg_q       <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            locked_q      <= locked_d;
            err_enc_q     <= err_enc_d;
            err_conf_q    <= err_conf_d;
            err_seq_q     <= err_seq_d;
            err_tim_q     <= err_tim_d;
            cycle_count_q <= cycle_count_d;
            dwell_q       <= dwell_d;
            emerg_q       <= emergency;
        end
    end

    assign phase        = phase_q;
    assign locked       = locked_q;
    assign err_encoding = err_enc_q;
    assign err_conflict = err_conf_q;
    assign err_sequence = err_seq_q;
    assign err_timing   = err_tim_q;
    assign err_any      = err_enc_q | err_conf_q | err_seq_q | err_tim_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a driver applies directed light
// sequences and queues the hand-computed registered response; a monitor pops
// and compares on every falling edge. A second instance with CNT_W=2 checks
// counter wrap.
module tb_traffic_light_monitor;

    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] X = 2'b11;

    logic       clk;
    logic       reset;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       emergency;
    logic       clear_errors;

    logic [2:0] phase, phase2;
    logic       locked, locked2;
    logic       e_enc, e_conf, e_seq, e_tim, e_any;
    logic       e_enc2, e_conf2, e_seq2, e_tim2, e_any2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] ph;
        logic       lk;
        logic [3:0] err;  // {encoding, conflict, sequence, timing}
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    traffic_light_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .ns_light     (ns_light),
        .ew_light     (ew_light),
        .emergency    (emergency),
        .clear_errors (clear_errors),
        .phase        (phase),
        .locked       (locked),
        .err_encoding (e_enc),
        .err_conflict (e_conf),
        .err_sequence (e_seq),
        .err_timing   (e_tim),
        .err_any      (e_any),
        .cycle_count  (cnt)
    );

    traffic_light_monitor #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .ns_light     (ns_light),
        .ew_light     (ew_light),
        .emergency    (emergency),
        .clear_errors (clear_errors),
        .phase        (phase2),
        .locked       (locked2),
        .err_encoding (e_enc2),
        .err_conflict (e_conf2),
        .err_sequence (e_seq2),
        .err_timing   (e_tim2),
        .err_any      (e_any2),
        .cycle_count  (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk("phase", int'(phase), int'(e.ph));
        chk("locked", int'(locked), int'(e.lk));
        chk("err_flags", int'({e_enc, e_conf, e_seq, e_tim}), int'(e.err));
        chk("err_any", int'(e_any), int'(|e.err));
        chk("cycle_count", int'(cnt), int'(e.cnt));
        chk("cycle_count_w2", int'(cnt2), int'(e.cnt[1:0]));
        chk("phase_w2", int'(phase2), int'(e.ph));
    endtask

    // Monitor: one registered response per driven cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            compare_all(sb.pop_front());
        end
    end

    // Drive n samples of one light pair; every response in the group must
    // match the same expected state. Entered and left at a falling edge.
    task automatic grp(input logic [1:0] ns, input logic [1:0] ew, input int n,
                       input bit em_last, input bit clr_first, input logic [2:0] ph,
                       input bit lk, input logic [3:0] err, input int c);
        exp_t e;
        e.ph  = ph;
        e.lk  = lk;
        e.err = err;
        e.cnt = 8'(c);
        for (int i = 0; i < n; i++) begin
            ns_light     = ns;
            ew_light     = ew;
            emergency    = em_last && (i == n - 1);
            clear_errors = clr_first && (i == 0);
            @(posedge clk);
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic full_cycle(input int c_at_ns_g);
        grp(Y, R, 2, 0, 0, 3'd1, 1, 4'b0000, c_at_ns_g - 1);
        grp(R, G, 8, 0, 0, 3'd2, 1, 4'b0000, c_at_ns_g - 1);
        grp(R, Y, 2, 0, 0, 3'd3, 1, 4'b0000, c_at_ns_g - 1);
        grp(G, R, 8, 0, 0, 3'd0, 1, 4'b0000, c_at_ns_g);
    endtask

    task automatic chk_reset_vals();
        exp_t e;
        e.ph  = 3'd7;
        e.lk  = 1'b0;
        e.err = 4'b0000;
        e.cnt = 8'd0;
        compare_all(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ns_light     = R;
        ew_light     = R;
        emergency    = 1'b0;
        clear_errors = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;

        // Normal operation: resync, then two full cycles.
        grp(G, R, 8, 0, 0, 3'd0, 0, 4'b0000, 0);
        full_cycle(1);
        full_cycle(2);

        // Conflict, then resync with no new error.
        grp(G, G, 1, 0, 0, 3'd7, 0, 4'b0100, 2);
        grp(G, R, 8, 0, 0, 3'd0, 0, 4'b0100, 2);
        grp(Y, R, 2, 0, 0, 3'd1, 1, 4'b0100, 2);
        grp(R, G, 8, 0, 0, 3'd2, 1, 4'b0100, 2);
        grp(R, Y, 2, 0, 0, 3'd3, 1, 4'b0100, 2);

        // Short green while locked -> timing error; clear it.
        grp(G, R, 5, 0, 0, 3'd0, 1, 4'b0100, 3);
        grp(Y, R, 2, 0, 0, 3'd1, 1, 4'b0101, 3);
        grp(R, G, 8, 1, 1, 3'd2, 1, 4'b0000, 3);

        // Emergency preemption, held 4, then back to NS_G: clean.
        grp(R, R, 4, 0, 0, 3'd4, 1, 4'b0000, 3);
        grp(G, R, 8, 0, 0, 3'd0, 1, 4'b0000, 3);
        // Second preemption, ALL_RED only 2 -> timing error on exit.
        grp(Y, R, 2, 0, 0, 3'd1, 1, 4'b0000, 3);
        grp(R, G, 8, 1, 0, 3'd2, 1, 4'b0000, 3);
        grp(R, R, 2, 0, 0, 3'd4, 1, 4'b0000, 3);
        grp(G, R, 8, 0, 0, 3'd0, 1, 4'b0001, 3);

        // Sequence errors and bad encoding.
        grp(R, G, 8, 0, 0, 3'd2, 1, 4'b0011, 3);
        grp(R, R, 3, 0, 0, 3'd4, 1, 4'b0011, 3);
        grp(R, X, 1, 0, 0, 3'd7, 0, 4'b1011, 3);

        // Clear and resync, then run on to wrap the 2-bit counter.
        grp(G, R, 8, 0, 1, 3'd0, 0, 4'b0000, 3);
        full_cycle(4);
        full_cycle(5);
        grp(Y, R, 1, 0, 0, 3'd1, 1, 4'b0000, 5);

        // Asynchronous reset mid NS_Y: outputs return without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        chk("locked_w2_reset", int'(locked2), 0);
        chk("err_any_w2_reset", int'(e_any2), 0);
        @(negedge clk);
        reset = 1'b0;
        grp(Y, R, 2, 0, 0, 3'd1, 0, 4'b0000, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
